// File: rtl/tetris_input_ctrl.sv
// Button conditioning and joystick auto-repeat for the tetris grid.
// Turns raw buttons and the stick ADC into single-cycle move commands.
module tetris_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYC  = 500000,
  parameter int unsigned DAS_DELAY_CYC = 12500000,
  parameter int unsigned DAS_RATE_CYC  = 4000000,
  parameter int unsigned DROP_RATE_CYC = 2500000,
  parameter int unsigned ADC_RIGHT_ON  = 2179,
  parameter int unsigned ADC_LEFT_ON   = 1121,
  parameter int unsigned ADC_HYST      = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s1_n,
  input  logic        s2_n,
  input  logic        joy_sel_n,
  input  logic [11:0] adc_value,
  input  logic        enable,
  output logic        move_left,
  output logic        move_right,
  output logic        move_down,
  output logic        rotate,
  output logic        pause,
  output logic        joy_active
);

  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int DASMAX = (DAS_DELAY_CYC > DAS_RATE_CYC) ?
                          DAS_DELAY_CYC : DAS_RATE_CYC;
  localparam int DSW = $clog2(DASMAX + 1);
  localparam int DRW = $clog2(DROP_RATE_CYC + 1);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [DSW-1:0] DLY_LD    = DSW'(DAS_DELAY_CYC - 1);
  localparam logic [DSW-1:0] RATE_LD   = DSW'(DAS_RATE_CYC - 1);
  localparam logic [DRW-1:0] DROP_LAST = DRW'(DROP_RATE_CYC - 1);
  localparam logic [11:0]    R_ON  = 12'(ADC_RIGHT_ON);
  localparam logic [11:0]    R_OFF = 12'(ADC_RIGHT_ON - ADC_HYST);
  localparam logic [11:0]    L_ON  = 12'(ADC_LEFT_ON);
  localparam logic [11:0]    L_OFF = 12'(ADC_LEFT_ON + ADC_HYST);

  typedef enum logic [1:0] {
    Z_NONE,
    Z_RIGHT,
    Z_LEFT
  } zone_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } das_e;

  // bit 0 = s1 (rotate), bit 1 = s2 (drop), bit 2 = joy_sel (pause)
  logic [2:0]     raw_n;
  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     stab_q, prev_q;
  logic [DBW-1:0] db_q [3];
  logic [2:0]     press;

  assign raw_n = {joy_sel_n, s2_n, s1_n};
  assign press = prev_q & ~stab_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      stab_q  <= '1;
      prev_q  <= '1;
      for (int i = 0; i < 3; i++) db_q[i] <= '0;
    end else begin
      sync1_q <= raw_n;
      sync2_q <= sync1_q;
      prev_q  <= stab_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == stab_q[i]) begin
          db_q[i] <= '0;
        end else if (db_q[i] == DB_LAST) begin
          stab_q[i] <= sync2_q[i];
          db_q[i]   <= '0;
        end else begin
          db_q[i] <= db_q[i] + 1'b1;
        end
      end
    end
  end

  logic           rotate_q, pause_q, down_q;
  logic [DRW-1:0] drop_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rotate_q <= 1'b0;
      pause_q  <= 1'b0;
      down_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      rotate_q <= enable & press[0];
      pause_q  <= press[2];
      if (!enable || stab_q[1]) begin
        down_q <= 1'b0;
        drop_q <= '0;
      end else if (press[1] || drop_q == DROP_LAST) begin
        down_q <= 1'b1;
        drop_q <= '0;
      end else begin
        down_q <= 1'b0;
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  zone_e zone_q, zone_d;
  logic  joy_q;

  // A full swing across the dead band jumps straight to the other side
  always_comb begin
    zone_d = zone_q;
    case (zone_q)
      Z_NONE: begin
        if (adc_value > R_ON)      zone_d = Z_RIGHT;
        else if (adc_value < L_ON) zone_d = Z_LEFT;
      end
      Z_RIGHT: begin
        if (adc_value < L_ON)       zone_d = Z_LEFT;
        else if (adc_value < R_OFF) zone_d = Z_NONE;
      end
      Z_LEFT: begin
        if (adc_value > R_ON)       zone_d = Z_RIGHT;
        else if (adc_value > L_OFF) zone_d = Z_NONE;
      end
      default: zone_d = Z_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zone_q <= Z_NONE;
      joy_q  <= 1'b0;
    end else begin
      zone_q <= zone_d;
      joy_q  <= (zone_d != Z_NONE);
    end
  end

  das_e           das_q;
  logic           dir_left_q;
  logic [DSW-1:0] das_cnt_q;
  logic           left_q, right_q;
  logic           zl;

  assign zl = (zone_q == Z_LEFT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      das_q      <= S_IDLE;
      dir_left_q <= 1'b0;
      das_cnt_q  <= '0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
    end else begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
      if (!enable || zone_q == Z_NONE) begin
        das_q     <= S_IDLE;
        das_cnt_q <= '0;
      end else if (das_q == S_IDLE || zl != dir_left_q) begin
        left_q     <= zl;
        right_q    <= ~zl;
        dir_left_q <= zl;
        das_cnt_q  <= DLY_LD;
        das_q      <= S_DELAY;
      end else if (das_cnt_q == '0) begin
        left_q    <= zl;
        right_q   <= ~zl;
        das_cnt_q <= RATE_LD;
        das_q     <= S_REPEAT;
      end else begin
        das_cnt_q <= das_cnt_q - 1'b1;
      end
    end
  end

  assign move_left  = left_q;
  assign move_right = right_q;
  assign move_down  = down_q;
  assign rotate     = rotate_q;
  assign pause      = pause_q;
  assign joy_active = joy_q;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Bench for tetris_input_ctrl: directed scenarios plus random
// stimulus, every cycle compared against a behavioural model.
module tb_tetris_input_ctrl;

  localparam int D    = 8;
  localparam int DLY  = 20;
  localparam int RATE = 5;
  localparam int DROP = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        s1_n = 1'b1;
  logic        s2_n = 1'b1;
  logic        joy_sel_n = 1'b1;
  logic [11:0] adc_value = 12'd2000;
  logic        enable = 1'b0;
  logic        move_left, move_right, move_down;
  logic        rotate, pause, joy_active;

  always #5 clk = ~clk;

  tetris_input_ctrl #(
    .DEBOUNCE_CYC (D),
    .DAS_DELAY_CYC(DLY),
    .DAS_RATE_CYC (RATE),
    .DROP_RATE_CYC(DROP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s1_n      (s1_n),
    .s2_n      (s2_n),
    .joy_sel_n (joy_sel_n),
    .adc_value (adc_value),
    .enable    (enable),
    .move_left (move_left),
    .move_right(move_right),
    .move_down (move_down),
    .rotate    (rotate),
    .pause     (pause),
    .joy_active(joy_active)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference model state (zone: 0 none, 1 right, 2 left)
  int m_stab[3], m_run[3], m_h1[3], m_h2[3];
  bit m_pend[3];
  int m_zone, m_dt, m_age, m_rdir;
  bit m_running;
  bit e_left, e_right, e_down, e_rot, e_pause, e_joy;

  int c_left = 0, c_right = 0, c_down = 0, c_rot = 0, c_pause = 0;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_stab[i] = 1; m_run[i] = 0;
      m_h1[i] = 1;   m_h2[i] = 1;
      m_pend[i] = 0;
    end
    m_zone = 0; m_dt = 0; m_age = 0; m_rdir = 0; m_running = 0;
    {e_left, e_right, e_down, e_rot, e_pause, e_joy} = '0;
  endtask

  task automatic model_edge();
    int raw[3];
    int lvl;
    bit fire;
    int a;
    raw[0] = s1_n; raw[1] = s2_n; raw[2] = joy_sel_n;
    a = adc_value;
    fire = 0;
    e_rot = enable && m_pend[0];
    e_pause = m_pend[2];
    e_down = 0;
    if (enable && m_pend[1]) begin
      e_down = 1; m_dt = 0;
    end else if (enable && m_stab[1] == 0) begin
      m_dt++;
      if (m_dt == DROP) begin e_down = 1; m_dt = 0; end
    end else begin
      m_dt = 0;
    end
    e_left = 0; e_right = 0;
    if (enable && m_zone != 0) begin
      if (m_running && m_zone == m_rdir) begin
        m_age++;
        if (m_age == DLY || (m_age > DLY && (m_age - DLY) % RATE == 0))
          fire = 1;
      end else begin
        m_running = 1; m_rdir = m_zone; m_age = 0; fire = 1;
      end
      if (fire) begin
        e_left = (m_zone == 2); e_right = (m_zone == 1);
      end
    end else begin
      m_running = 0;
    end
    if (m_zone == 0) begin
      if (a > 2179) m_zone = 1;
      else if (a < 1121) m_zone = 2;
    end else if (m_zone == 1) begin
      if (a < 1121) m_zone = 2;
      else if (a < 2179 - 64) m_zone = 0;
    end else begin
      if (a > 2179) m_zone = 1;
      else if (a > 1121 + 64) m_zone = 0;
    end
    e_joy = (m_zone != 0);
    for (int i = 0; i < 3; i++) begin
      lvl = m_h2[i];
      m_h2[i] = m_h1[i];
      m_h1[i] = raw[i];
      m_pend[i] = 0;
      if (lvl != m_stab[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_pend[i] = (lvl == 0);
          m_stab[i] = lvl;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
    chk("move_left", move_left, e_left);
    chk("move_right", move_right, e_right);
    chk("move_down", move_down, e_down);
    chk("rotate", rotate, e_rot);
    chk("pause", pause, e_pause);
    chk("joy_active", joy_active, e_joy);
    chk("lr_excl", move_left & move_right, 0);
    c_left += move_left;  c_right += move_right;
    c_down += move_down;  c_rot += rotate;
    c_pause += pause;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outs"},
        {move_left, move_right, move_down, rotate, pause, joy_active}, 0);
  endtask

  int base, base2, lat;
  int adc_pick[10] = '{2179, 2180, 2114, 2115, 1121,
                       1120, 1185, 1186, 0, 4095};

  initial begin
    model_reset();
    #2 reset_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    enable = 1'b1;
    repeat (3) step();

    // bouncing rotate press
    base = c_rot;
    s1_n = 0; step(); s1_n = 1; step();
    s1_n = 0; step(); s1_n = 1; step();
    s1_n = 0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (rotate && lat == 0) lat = i;
    end
    chk("t1_latency", lat, D + 3);
    s1_n = 1;
    repeat (15) step();
    chk("t1_rot_count", c_rot - base, 1);

    // stick held right
    base = c_right; base2 = c_left;
    adc_value = 12'd3000;
    repeat (60) step();
    chk("t2_right_count", c_right - base, 9);
    chk("t2_left_count", c_left - base2, 0);
    chk("t2_joy", joy_active, 1);

    adc_value = 12'd2150; repeat (10) step();
    chk("t3_joy_hyst", joy_active, 1);
    adc_value = 12'd2100; repeat (10) step();
    chk("t3_joy_off", joy_active, 0);
    adc_value = 12'd3000; repeat (10) step();
    base = c_left;
    adc_value = 12'd500; repeat (22) step();
    chk("t4_left_count", c_left - base, 2);
    adc_value = 12'd2000; repeat (5) step();

    // soft drop hold
    base = c_down;
    s2_n = 0; repeat (30) step();
    s2_n = 1; repeat (15) step();
    chk("t5_down_count", c_down - base, 5);

    // reset in the middle of a hold
    s2_n = 0; repeat (15) step();
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all_zero("t5_midreset");
    @(negedge clk);
    reset_n = 1'b1;
    base = c_down;
    repeat (15) step();
    chk("t5_down_after_rst", c_down - base, 1);
    s2_n = 1; repeat (15) step();

    // disabled gameplay, pause still live
    base = c_rot; base2 = c_pause; lat = c_right;
    enable = 0; adc_value = 12'd3000;
    s1_n = 0; joy_sel_n = 0; repeat (20) step();
    s1_n = 1; joy_sel_n = 1; repeat (15) step();
    chk("t6_rot_count", c_rot - base, 0);
    chk("t6_pause_count", c_pause - base2, 1);
    chk("t6_right_count", c_right - lat, 0);
    enable = 1;
    step();
    chk("t6_enable_right", move_right, 1);

    // random soak
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 0)
          adc_value = 12'(adc_pick[$urandom_range(0, 9)]);
        else
          adc_value = 12'($urandom_range(0, 4095));
      end
      if ($urandom_range(0, 11) == 0) s1_n = ~s1_n;
      if ($urandom_range(0, 11) == 0) s2_n = ~s2_n;
      if ($urandom_range(0, 15) == 0) joy_sel_n = ~joy_sel_n;
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
